// File: rtl/tomasulo_pkg.sv
// Shared opcode constants, issue-op encoding and decoded-entry type for the
// fetch/issue front end.
package tomasulo_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_MUL = 4'b0010;

  typedef enum logic [1:0] {
    ISS_ADD = 2'd0,
    ISS_SUB = 2'd1,
    ISS_MUL = 2'd2
  } iss_op_e;

  typedef struct packed {
    iss_op_e    op;
    logic [3:0] rs1;
    logic [3:0] rs2;
    logic [3:0] rd;
    logic [3:0] pc;
  } dq_entry_t;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DRAIN = 2'd1,
    S_DONE  = 2'd2,
    S_TRAP  = 2'd3
  } fiq_state_e;

  function automatic logic is_legal(input logic [3:0] opcode);
    return (opcode == OP_ADD) || (opcode == OP_SUB) || (opcode == OP_MUL);
  endfunction

  function automatic iss_op_e encode_op(input logic [3:0] opcode);
    case (opcode)
      OP_SUB:  return ISS_SUB;
      OP_MUL:  return ISS_MUL;
      default: return ISS_ADD;
    endcase
  endfunction

endpackage

// File: rtl/dq_fifo.sv
// Synchronous FIFO of decoded entries; head is read combinationally, so a
// pushed entry becomes visible only after the push edge (no bypass).
module dq_fifo
  import tomasulo_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  dq_entry_t     push_data,
  input  logic          pop,
  output dq_entry_t     head,
  output logic [CW-1:0] count
);

  dq_entry_t     mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_issue_queue.sv
// In-order fetch, decode and issue queue for a small Tomasulo front end.
// Optional illegal-opcode trap is enabled by defining ILLEGAL_OP_TRAP_EN.
module fetch_issue_queue
  import tomasulo_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int PROG_LEN = 6
) (
  input  logic        clk1,
  input  logic        rst,
  output logic [3:0]  pc,
  output logic        fetch_en,
  input  logic [15:0] instr_in,
  output logic        iss_valid,
  input  logic        iss_ready,
  output logic [1:0]  iss_op,
  output logic [3:0]  iss_rs1,
  output logic [3:0]  iss_rs2,
  output logic [3:0]  iss_rd,
  output logic [3:0]  iss_pc,
  output logic        done,
  output logic        illegal_op,
  output logic [1:0]  fsm_state
);

  localparam int CW = $clog2(DEPTH) + 1;

  fiq_state_e    state;
  logic [4:0]    fetched;
  logic          inflight;
  logic [3:0]    inflight_pc;
  logic [CW-1:0] count;
  dq_entry_t     head;
  dq_entry_t     cap_entry;
  logic          cap_legal;
  logic          push;
  logic          pop;
  logic          trap_hit;
  logic          credit_ok;

  assign cap_legal = is_legal(instr_in[15:12]);
  assign cap_entry = '{op:  encode_op(instr_in[15:12]),
                       rs1: instr_in[11:8],
                       rs2: instr_in[7:4],
                       rd:  instr_in[3:0],
                       pc:  inflight_pc};

`ifdef ILLEGAL_OP_TRAP_EN
  assign trap_hit = inflight && !cap_legal && (state != S_TRAP);
`else
  assign trap_hit   = 1'b0;
  assign illegal_op = 1'b0;
`endif

  // Valid/ready: an entry leaves the queue on a cycle where iss_valid and
  // iss_ready are both high; iss_* hold steady while valid waits for ready.
  assign push      = inflight && cap_legal && (state != S_TRAP);
  assign iss_valid = (count != '0);
  assign pop       = iss_valid && iss_ready;

  // Credit counts the in-flight word so the queue can never overflow.
  assign credit_ok = (int'(count) + int'(inflight)) < DEPTH;
  assign fetch_en  = !rst && (state == S_RUN) && (fetched < 5'(PROG_LEN))
                     && credit_ok && !trap_hit;

  assign iss_op    = iss_valid ? head.op  : 2'd0;
  assign iss_rs1   = iss_valid ? head.rs1 : 4'd0;
  assign iss_rs2   = iss_valid ? head.rs2 : 4'd0;
  assign iss_rd    = iss_valid ? head.rd  : 4'd0;
  assign iss_pc    = iss_valid ? head.pc  : 4'd0;
  assign done      = (state == S_DONE);
  assign fsm_state = state;

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      state       <= S_RUN;
      pc          <= 4'd0;
      fetched     <= 5'd0;
      inflight    <= 1'b0;
      inflight_pc <= 4'd0;
`ifdef ILLEGAL_OP_TRAP_EN
      illegal_op  <= 1'b0;
`endif
    end else begin
      inflight <= fetch_en;
      if (fetch_en) begin
        pc          <= pc + 4'd1;
        fetched     <= fetched + 5'd1;
        inflight_pc <= pc;
      end
      case (state)
        S_RUN: begin
          if (trap_hit) state <= S_TRAP;
          else if (fetched == 5'(PROG_LEN)) state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (trap_hit) state <= S_TRAP;
          else if (!inflight && (count == '0)) state <= S_DONE;
        end
        default: ;
      endcase
`ifdef ILLEGAL_OP_TRAP_EN
      if (trap_hit) illegal_op <= 1'b1;
`endif
    end
  end

  dq_fifo #(.DEPTH(DEPTH)) u_dq_fifo (
    .clk       (clk1),
    .rst       (rst),
    .push      (push),
    .push_data (cap_entry),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

endmodule

// File: tb/tb_fetch_issue_queue.sv
// Bench for fetch_issue_queue: two instances (PROG_LEN 6 and 16) with
// instruction-memory responders, a scoreboard queue and random stimulus.
module tb_fetch_issue_queue;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b;
  logic [3:0]  pc_a, pc_b;
  logic        fetch_en_a, fetch_en_b;
  logic [15:0] instr_a = '0, instr_b = '0;
  logic        iss_valid_a, iss_valid_b;
  logic        iss_ready_a = 1'b0, iss_ready_b = 1'b0;
  logic [1:0]  iss_op_a, iss_op_b;
  logic [3:0]  iss_rs1_a, iss_rs2_a, iss_rd_a, iss_pc_a;
  logic [3:0]  iss_rs1_b, iss_rs2_b, iss_rd_b, iss_pc_b;
  logic        done_a, done_b, illegal_a, illegal_b;
  logic [1:0]  st_a, st_b;

  logic [15:0] imem_a [16];
  logic [15:0] imem_b [16];
  logic [17:0] exp_q_a[$];
  logic [17:0] exp_q_b[$];
  logic [17:0] exp_e_a, exp_e_b;

  int chk_cnt = 0;
  int pass_cnt = 0;
  int fetch_cnt_a = 0, issue_cnt_a = 0;
  int fetch_cnt_b = 0, issue_cnt_b = 0;
  int ready_mode = 0;
  bit occ_chk = 1'b0;

  fetch_issue_queue #(.DEPTH(4), .PROG_LEN(6)) dut_a (
    .clk1(clk), .rst(rst_a), .pc(pc_a), .fetch_en(fetch_en_a), .instr_in(instr_a),
    .iss_valid(iss_valid_a), .iss_ready(iss_ready_a), .iss_op(iss_op_a),
    .iss_rs1(iss_rs1_a), .iss_rs2(iss_rs2_a), .iss_rd(iss_rd_a), .iss_pc(iss_pc_a),
    .done(done_a), .illegal_op(illegal_a), .fsm_state(st_a)
  );

  fetch_issue_queue #(.DEPTH(4), .PROG_LEN(16)) dut_b (
    .clk1(clk), .rst(rst_b), .pc(pc_b), .fetch_en(fetch_en_b), .instr_in(instr_b),
    .iss_valid(iss_valid_b), .iss_ready(iss_ready_b), .iss_op(iss_op_b),
    .iss_rs1(iss_rs1_b), .iss_rs2(iss_rs2_b), .iss_rd(iss_rd_b), .iss_pc(iss_pc_b),
    .done(done_b), .illegal_op(illegal_b), .fsm_state(st_b)
  );

  // Instruction memory: word is on instr_in the cycle after the fetch.
  always @(posedge clk) begin
    if (fetch_en_a) instr_a <= imem_a[pc_a];
    if (fetch_en_b) instr_b <= imem_b[pc_b];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [15:0] rand_word(input bit allow_illegal);
    logic [3:0] op;
    op = 4'($urandom_range(0, 2));
    if (allow_illegal && ($urandom_range(0, 4) == 0)) op = 4'($urandom_range(3, 15));
    return {op, 12'($urandom_range(0, 4095))};
  endfunction

  // Reference model: legal words issue in program order; with the trap
  // build, nothing at or after the first illegal word issues.
  task automatic push_expected_a();
    logic [15:0] w;
    for (int p = 0; p < 6; p++) begin
      w = imem_a[p];
      if (w[15:12] <= 4'd2) exp_q_a.push_back({w[13:12], w[11:0], 4'(p)});
`ifdef ILLEGAL_OP_TRAP_EN
      else break;
`endif
    end
  endtask

  // Ready driver, changing inputs just after the active edge.
  initial forever begin
    @(posedge clk); #1;
    case (ready_mode)
      0: iss_ready_a = 1'b1;
      1: iss_ready_a = !iss_ready_a;
      2: iss_ready_a = 1'($urandom_range(0, 1));
      default: iss_ready_a = 1'b0;
    endcase
    iss_ready_b = 1'($urandom_range(0, 1));
  end

  // Monitor for instance A.
  always @(negedge clk) begin
    if (rst_a) begin
      fetch_cnt_a = 0;
      issue_cnt_a = 0;
      exp_q_a.delete();
    end else begin
      if (fetch_en_a) begin
        check("fetch_pc_a", 32'(pc_a), 32'(fetch_cnt_a % 16));
        fetch_cnt_a++;
      end
      if (iss_valid_a && iss_ready_a) begin
        if (exp_q_a.size() == 0) begin
          chk_cnt++;
          $display("FAIL issue_a: got issue pc=%0d expected no issue", iss_pc_a);
        end else begin
          exp_e_a = exp_q_a.pop_front();
          check("issue_a", {14'd0, iss_op_a, iss_rs1_a, iss_rs2_a, iss_rd_a, iss_pc_a}, {14'd0, exp_e_a});
        end
        issue_cnt_a++;
      end
      if (occ_chk) check("occupancy_a", 32'((fetch_cnt_a - issue_cnt_a) <= 4), 32'd1);
    end
  end

  // Monitor for instance B.
  always @(negedge clk) begin
    if (rst_b) begin
      fetch_cnt_b = 0;
      issue_cnt_b = 0;
    end else begin
      if (fetch_en_b) begin
        check("fetch_pc_b", 32'(pc_b), 32'(fetch_cnt_b % 16));
        fetch_cnt_b++;
      end
      if (iss_valid_b && iss_ready_b) begin
        if (exp_q_b.size() == 0) begin
          chk_cnt++;
          $display("FAIL issue_b: got issue pc=%0d expected no issue", iss_pc_b);
        end else begin
          exp_e_b = exp_q_b.pop_front();
          check("issue_b", {14'd0, iss_op_b, iss_rs1_b, iss_rs2_b, iss_rd_b, iss_pc_b}, {14'd0, exp_e_b});
        end
        issue_cnt_b++;
      end
    end
  end

  task automatic reset_a();
    rst_a = 1'b1;
    #1;
    check("reset_out_a", 32'({pc_a, fetch_en_a, iss_valid_a, iss_op_a, iss_rs1_a, iss_rs2_a,
                              iss_rd_a, iss_pc_a, done_a, illegal_a}), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_a = 1'b0;
    @(negedge clk);
    check("first_fetch_a", 32'({fetch_en_a, pc_a}), 32'h10);
    push_expected_a();
  endtask

  task automatic wait_done_a();
    int n = 0;
    while (!done_a && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("done_a", 32'(done_a), 32'd1);
    check("drained_a", 32'(exp_q_a.size()), 32'd0);
    check("fetch_total_a", 32'(fetch_cnt_a), 32'd6);
  endtask

  task automatic wait_pc2_fetch_a();
    int n = 0;
    while (!(fetch_en_a && pc_a == 4'd2) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("saw_fetch_pc2_a", 32'(fetch_en_a && pc_a == 4'd2), 32'd1);
  endtask

  logic [15:0] dir_prog [6] = '{16'h2123, 16'h0314, 16'h0426, 16'h0567, 16'h2678, 16'h15B5};
  logic [15:0] trap_prog [6] = '{16'h0111, 16'h1222, 16'h3123, 16'h2334, 16'h0445, 16'h1556};

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    for (int i = 0; i < 16; i++) begin
      imem_a[i] = '0;
      imem_b[i] = '0;
    end

    // Directed six-instruction program, always ready.
    for (int i = 0; i < 6; i++) imem_a[i] = dir_prog[i];
    ready_mode = 0;
    reset_a();
    wait_done_a();

    // Back-pressure: nothing accepted, queue fills to DEPTH and holds.
    for (int i = 0; i < 6; i++) imem_a[i] = rand_word(1'b0);
    ready_mode = 3;
    @(posedge clk); #1;
    reset_a();
    repeat (30) @(negedge clk);
    check("stall_fetches_a", 32'(fetch_cnt_a), 32'd4);
    check("stall_fetch_en_a", 32'(fetch_en_a), 32'd0);
    check("stall_valid_a", 32'(iss_valid_a), 32'd1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("stall_hold_a", {14'd0, iss_op_a, iss_rs1_a, iss_rs2_a, iss_rd_a, iss_pc_a}, {14'd0, exp_q_a[0]});
    end
    ready_mode = 0;
    wait_done_a();

    // Toggling ready with concurrent push/pop; occupancy bounded.
    for (int i = 0; i < 6; i++) imem_a[i] = rand_word(1'b0);
    ready_mode = 1;
    occ_chk = 1'b1;
    @(posedge clk); #1;
    reset_a();
    wait_done_a();
    occ_chk = 1'b0;

    // Random programs under random ready.
    for (int t = 0; t < 4; t++) begin
`ifdef ILLEGAL_OP_TRAP_EN
      for (int i = 0; i < 6; i++) imem_a[i] = rand_word(1'b0);
`else
      for (int i = 0; i < 6; i++) imem_a[i] = rand_word(1'b1);
`endif
      ready_mode = 2;
      @(posedge clk); #1;
      reset_a();
      wait_done_a();
    end

    // Illegal word at pc 2.
    for (int i = 0; i < 6; i++) imem_a[i] = trap_prog[i];
    ready_mode = 0;
    @(posedge clk); #1;
    reset_a();
    wait_pc2_fetch_a();
    @(negedge clk);
    check("illegal_early_a", 32'(illegal_a), 32'd0);
    @(negedge clk);
`ifdef ILLEGAL_OP_TRAP_EN
    check("illegal_op_a", 32'(illegal_a), 32'd1);
    repeat (30) @(negedge clk);
    check("trap_fetches_a", 32'(fetch_cnt_a), 32'd3);
    check("trap_done_a", 32'(done_a), 32'd0);
    check("trap_drained_a", 32'(exp_q_a.size()), 32'd0);
`else
    check("illegal_op_a", 32'(illegal_a), 32'd0);
    wait_done_a();
    check("issued_count_a", 32'(issue_cnt_a), 32'd5);
`endif

    // Reset mid-run with pc 2 in flight; stale word must not be enqueued.
    for (int i = 0; i < 6; i++) imem_a[i] = dir_prog[i];
    ready_mode = 0;
    @(posedge clk); #1;
    reset_a();
    wait_pc2_fetch_a();
    @(posedge clk); #1;
    reset_a();
    wait_done_a();
    check("issued_after_reset_a", 32'(issue_cnt_a), 32'd6);

    // PROG_LEN=16 instance: full pc range, no wrap refetch.
    for (int i = 0; i < 16; i++) begin
      imem_b[i] = rand_word(1'b0);
      exp_q_b.push_back({imem_b[i][13:12], imem_b[i][11:0], 4'(i)});
    end
    check("reset_out_b", 32'({pc_b, fetch_en_b, iss_valid_b, done_b, illegal_b}), 32'd0);
    @(posedge clk); #1 rst_b = 1'b0;
    begin
      int n = 0;
      while (!done_b && n < 600) begin
        @(negedge clk);
        n++;
      end
    end
    check("done_b", 32'(done_b), 32'd1);
    check("drained_b", 32'(exp_q_b.size()), 32'd0);
    repeat (10) @(negedge clk);
    check("fetch_total_b", 32'(fetch_cnt_b), 32'd16);
    check("issue_total_b", 32'(issue_cnt_b), 32'd16);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/fetch_issue_queue.md
FETCH_ISSUE_QUEUE -- requirements
Module: fetch_issue_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning decoded-instruction queue entries (power of two, 2..8).
REQ-002 SHALL have parameter PROG_LEN, default 6, meaning number of program instructions fetched (1..16).
REQ-003 SHALL have port clk1, input, 1 bit, meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit, meaning asynchronous active-high reset.
REQ-005 SHALL have port pc, output, 4 bits, meaning instruction memory address driven this cycle.
REQ-006 SHALL have port fetch_en, output, 1 bit, meaning pc is a real fetch this cycle.
REQ-007 SHALL have port instr_in, input, 16 bits, meaning memory word, valid one cycle after the fetch_en cycle.
REQ-008 SHALL have port iss_valid, output, 1 bit, meaning the head entry is presented.
REQ-009 SHALL have port iss_ready, input, 1 bit, meaning the reservation-station side accepts the head.
REQ-010 SHALL have port iss_op, output, 2 bits, meaning decoded op (0 add, 1 sub, 2 mul).
REQ-011 SHALL have ports iss_rs1, iss_rs2, iss_rd, outputs, 4 bits each, meaning source/destination registers.
REQ-012 SHALL have port iss_pc, output, 4 bits, meaning the address the head entry was fetched from.
REQ-013 SHALL have port done, output, 1 bit, meaning all PROG_LEN instructions fetched, none in flight, queue empty.
REQ-014 SHALL have port illegal_op, output, 1 bit, meaning sticky illegal-opcode trap flag.

Function
REQ-015 SHALL decode instr_in as opcode[15:12], rs1[11:8], rs2[7:4], rd[3:0]; opcodes 0000/0001/0010 legal, all others illegal.
REQ-016 SHALL assert fetch_en only in state RUN when fetched-count < PROG_LEN and (queue count + in-flight) < DEPTH.
REQ-017 SHALL increment pc each fetch_en cycle; fetched-count SHALL be 5 bits so PROG_LEN=16 does not wrap; pc holds its value when fetch_en is low.
REQ-018 SHALL capture instr_in at the end of the cycle following each fetch_en cycle (one-bit in-flight pipeline) and push legal instructions with their pc.
REQ-019 SHALL pop the head on iss_valid and iss_ready; simultaneous push and pop SHALL leave count unchanged; the credit rule of REQ-016 SHALL make overflow impossible.
REQ-020 SHALL present a pushed entry on iss_valid no earlier than the cycle after the push (no bypass); iss_* fields SHALL be stable while iss_valid and not iss_ready.
REQ-021 SHALL implement states RUN, DRAIN, DONE (plus TRAP when configured): RUN to DRAIN when fetched-count reaches PROG_LEN; DRAIN to DONE when in-flight clear and queue empty; DONE terminal until reset.
REQ-022 SHALL assert done exactly while in DONE.

Reset
REQ-023 SHALL, on rst asynchronously, set pc=0, fetched-count=0, in-flight=0, queue empty, state RUN, and drive fetch_en=0, iss_valid=0, iss_* fields=0, done=0, illegal_op=0; an in-flight fetch at reset SHALL be discarded.
REQ-024 SHALL assert fetch_en with pc=0 in the first cycle after rst deasserts.

Configuration
REQ-025 SHALL, with ILLEGAL_OP_TRAP_EN defined, on capturing an illegal opcode: not enqueue it, set illegal_op, enter TRAP (fetch_en held 0), still issue queued entries, never assert done.
REQ-026 SHALL, without ILLEGAL_OP_TRAP_EN, drop illegal opcodes silently, continue fetching, tie illegal_op to 0.

Structure
REQ-027 SHALL take opcode constants (OP_ADD, OP_SUB, OP_MUL), the 2-bit op encoding and the decoded-entry struct typedef from shared package tomasulo_pkg.
REQ-028 SHALL instantiate one sub-module dq_fifo (DEPTH-entry synchronous FIFO of decoded entries, count output).

Verification
REQ-029 SHALL cover: 6-instruction program (mul r3 r1 r2 ... sub r5 r5 r11), iss_ready=1 -> six issues in order, iss_pc 0..5, iss_op 2,0,0,0,2,1, done high after last pop.
REQ-030 SHALL cover: iss_ready=0 throughout -> fetch_en stops after 4 fetches, queue holds pc 0..3, iss fields stable, no loss.
REQ-031 SHALL cover: iss_ready toggling every cycle with simultaneous push/pop -> order preserved, count never exceeds 4.
REQ-032 SHALL cover: word 0x3123 at pc 2, ILLEGAL_OP_TRAP_EN defined -> illegal_op=1 next cycle, pc 0,1 issued, no further fetch, done=0; undefined -> five entries issued, done=1.
REQ-033 SHALL cover: rst pulsed mid-run with one fetch in flight -> all outputs zero immediately, refetch from pc=0, stale instr_in not enqueued.
REQ-034 SHALL cover: PROG_LEN=16 -> pc 0..15 fetched once, no wrap refetch, done asserted.
